// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver. Each bit is judged by a 3-sample
// majority vote around its centre, DATA_WIDTH data bits arrive LSB first, with
// optional parity and one or two stop bits. Frame results are reported as
// registered single-cycle pulses.
// Optional break detection is compiled in by defining UART_RX_BREAK_DET_EN.
module uart_rx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      Par_Err,
    output logic                      Stp_Err,
    output logic                      Break
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] MIN_P    = PRESCALE_WIDTH'(6);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] TWO      = PRESCALE_WIDTH'(2);
    localparam logic [3:0]                LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                    r_state, w_nextState;
    logic [PRESCALE_WIDTH-1:0] r_edgeCnt, w_edgeCntNext;
    logic [PRESCALE_WIDTH-1:0] r_p, w_pEven, w_pEff;
    logic [PRESCALE_WIDTH-1:0] w_half, w_hm1, w_hp1, w_hp2, w_last;
    logic [3:0]                r_bitCnt, w_bitCntNext;
    logic [DATA_WIDTH-1:0]     r_shift, w_shiftNext;
    logic [2:0]                r_samp;
    logic                      r_parEn, r_parTyp, r_stop2;
    logic                      r_parErr, w_parErrNext;
    logic                      r_stpErr, w_stpErrNext;
    logic                      w_latch, w_sampleEn, w_edgeLast, w_maj;
    logic                      w_dvNext, w_peNext, w_seNext;
`ifdef UART_RX_BREAK_DET_EN
    logic                      r_zero, w_zeroNext;
    logic                      r_armed, w_armedNext;
    logic [PRESCALE_WIDTH-1:0] r_hiCnt, w_hiCntNext;
    logic                      w_brNext;
`endif

    // Odd prescale values round down to even; anything below 6 leaves no room
    // for three samples plus a settled vote, so it is clamped up to 6.
    assign w_pEven    = Prescale & ~ONE;
    assign w_pEff     = (w_pEven < MIN_P) ? MIN_P : w_pEven;
    assign w_half     = r_p >> 1;
    assign w_hm1      = w_half - ONE;
    assign w_hp1      = w_half + ONE;
    assign w_hp2      = w_half + TWO;
    assign w_last     = r_p - ONE;
    assign w_edgeLast = (r_edgeCnt == w_last);
    assign w_maj      = (r_samp[0] & r_samp[1]) | (r_samp[1] & r_samp[2]) |
                        (r_samp[0] & r_samp[2]);
    assign w_sampleEn = (r_state != S_IDLE) && (r_state != S_DONE);

    // State register; an asynchronous reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_nextState;
    end

    // Next-state logic, bit counting, shifting, error tracking and pulse selection.
    always_comb begin
        w_nextState   = r_state;
        w_edgeCntNext = r_edgeCnt;
        w_bitCntNext  = r_bitCnt;
        w_shiftNext   = r_shift;
        w_parErrNext  = r_parErr;
        w_stpErrNext  = r_stpErr;
        w_latch       = 1'b0;
        w_dvNext      = 1'b0;
        w_peNext      = 1'b0;
        w_seNext      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        w_zeroNext    = r_zero;
        w_armedNext   = r_armed;
        w_hiCntNext   = r_hiCnt;
        w_brNext      = 1'b0;
`endif
        if (w_sampleEn) w_edgeCntNext = w_edgeLast ? '0 : r_edgeCnt + ONE;

        case (r_state)
            S_IDLE: begin
                w_edgeCntNext = '0;
                w_bitCntNext  = '0;
`ifdef UART_RX_BREAK_DET_EN
                if (!r_armed) begin
                    if (!RX_IN) begin
                        w_hiCntNext = '0;
                    end else if (r_hiCnt == w_last) begin
                        w_armedNext = 1'b1;
                        w_hiCntNext = '0;
                    end else begin
                        w_hiCntNext = r_hiCnt + ONE;
                    end
                end else
`endif
                if (!RX_IN) begin
                    w_nextState  = S_START;
                    w_latch      = 1'b1;
                    w_parErrNext = 1'b0;
                    w_stpErrNext = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    w_zeroNext   = 1'b1;
`endif
                end
            end
            S_START: begin
                if (w_edgeLast) w_nextState = w_maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_edgeLast) begin
                    w_shiftNext = {w_maj, r_shift[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                    w_zeroNext  = r_zero & ~w_maj;
`endif
                    if (r_bitCnt == LAST_BIT) begin
                        w_bitCntNext = '0;
                        w_nextState  = r_parEn ? S_PARITY : S_STOP1;
                    end else begin
                        w_bitCntNext = r_bitCnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_edgeLast) begin
                    if (w_maj != ((^r_shift) ^ r_parTyp)) w_parErrNext = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    w_zeroNext  = r_zero & ~w_maj;
`endif
                    w_nextState = S_STOP1;
                end
            end
            S_STOP1: begin
                if (r_edgeCnt == w_hp2) begin
                    if (!w_maj) w_stpErrNext = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    w_zeroNext = r_zero & ~w_maj;
`endif
                    if (!r_stop2) begin
                        w_nextState   = S_DONE;
                        w_edgeCntNext = '0;
                    end
                end
                if (r_stop2 && w_edgeLast) w_nextState = S_STOP2;
            end
            S_STOP2: begin
                if (r_edgeCnt == w_hp2) begin
                    if (!w_maj) w_stpErrNext = 1'b1;
                    w_nextState   = S_DONE;
                    w_edgeCntNext = '0;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                w_armedNext = ~r_zero;
                w_hiCntNext = '0;
                if (r_zero) w_brNext = 1'b1;
                else
`endif
                if (r_stpErr)      w_seNext = 1'b1;
                else if (r_parErr) w_peNext = 1'b1;
                else               w_dvNext = 1'b1;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath registers: counters, latched frame configuration, vote samples,
    // and the registered result pulses and output word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edgeCnt  <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_samp     <= '0;
            r_p        <= MIN_P;
            r_parEn    <= 1'b0;
            r_parTyp   <= 1'b0;
            r_stop2    <= 1'b0;
            r_parErr   <= 1'b0;
            r_stpErr   <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            r_edgeCnt  <= w_edgeCntNext;
            r_bitCnt   <= w_bitCntNext;
            r_shift    <= w_shiftNext;
            r_parErr   <= w_parErrNext;
            r_stpErr   <= w_stpErrNext;
            if (w_latch) begin
                r_p      <= w_pEff;
                r_parEn  <= PAR_EN;
                r_parTyp <= PAR_TYP;
                r_stop2  <= STOP2;
            end
            if (w_sampleEn) begin
                if (r_edgeCnt == w_hm1)  r_samp[0] <= RX_IN;
                if (r_edgeCnt == w_half) r_samp[1] <= RX_IN;
                if (r_edgeCnt == w_hp1)  r_samp[2] <= RX_IN;
            end
            Data_Valid <= w_dvNext;
            Par_Err    <= w_peNext;
            Stp_Err    <= w_seNext;
            if (w_dvNext) P_DATA <= r_shift;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // Break tracking: all-zero frame flag, re-arm counter and the Break pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_zero  <= 1'b0;
            r_armed <= 1'b1;
            r_hiCnt <= '0;
            Break   <= 1'b0;
        end else begin
            r_zero  <= w_zeroNext;
            r_armed <= w_armedNext;
            r_hiCnt <= w_hiCntNext;
            Break   <= w_brNext;
        end
    end
`else
    assign Break = 1'b0;
`endif

endmodule
